// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width, FIFO occupancy width helper
// and the push-outcome encoding used by the frame FIFO.
package spi_pkg;

    localparam int SPI_DW = 16;

    typedef enum logic [1:0] {
        PUSH_NONE  = 2'd0,
        PUSH_WRITE = 2'd1,
        PUSH_DROP  = 2'd2
    } push_e;

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_word_fifo_sync_2ff.sv
// Two-flop single-bit synchroniser with a parameterised reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/spi_word_fifo.sv
// Captures the SPI slave's word at each chip-select rising edge (end of frame)
// into a small FIFO read out through valid/ready, with debug frame/drop counters.
module spi_word_fifo
    import spi_pkg::*;
#(
    parameter int DW    = SPI_DW,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cs,
    input  logic [DW-1:0]               rx_word,
    output logic [DW-1:0]               out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [occ_width(DEPTH)-1:0] count,
    output logic                        overflow,
    input  logic                        ovf_clr,
    output logic [CNTW-1:0]             frame_count,
    output logic [CNTW-1:0]             drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic            cs_s2;
    logic            cs_s3_q;
    logic            eof;
    logic            full;
    logic            pop;
    push_e           push_kind;

    logic [DW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [CNTW-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d_i (cs),
        .q_o (cs_s2)
    );

    // History flop resets high so a cs already high at release never looks like a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s3_q <= 1'b1;
        end else begin
            cs_s3_q <= cs_s2;
        end
    end

    assign eof  = cs_s2 & ~cs_s3_q;
    assign full = (count_q == CW'(DEPTH));
    assign pop  = out_valid & out_ready;

    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    always_comb begin
        push_kind = PUSH_NONE;
        if (eof) begin
            push_kind = (!full || pop) ? PUSH_WRITE : PUSH_DROP;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (push_kind == PUSH_WRITE) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if ((push_kind == PUSH_WRITE) && !pop) begin
            count_d = count_q + CW'(1);
        end else if ((push_kind != PUSH_WRITE) && pop) begin
            count_d = count_q - CW'(1);
        end

        if (eof) begin
            frame_cnt_d = frame_cnt_q + CNTW'(1);
        end

        if (push_kind == PUSH_DROP) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNTW'(1);
            end
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage is reset so the empty-FIFO head never shows X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_kind == PUSH_WRITE) begin
            mem_q[wr_ptr_q] <= rx_word;
        end
    end

    assign out_data    = mem_q[rd_ptr_q];
    assign out_valid   = (count_q != '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;

endmodule
